// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage and its combinational execution unit.
package alu_pkg;

  localparam int A_W    = 6;
  localparam int B_W    = 4;
  localparam int RES_W  = 9;
  localparam int WAIT_W = 3;

  localparam logic [RES_W-1:0] DIV0_CODE = 9'h1FF;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

endpackage

// File: rtl/alu_exec_unit.sv
// Combinational add/subtract, 4x4 multiply and 6/3 divide, muxed by opcode into one result word.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic [1:0]       op,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [RES_W-1:0] data,
  output logic             carry,
  output logic             err
);

  op_e        op_sel;
  logic       sub_m;
  logic [3:0] b_x;
  logic [4:0] sum;
  logic [7:0] prod;
  logic [2:0] divisor;
  logic [2:0] safe_div;
  logic       div_zero;
  logic [5:0] quot;
  logic [2:0] rem;

  assign op_sel = op_e'(op);

  // Subtract is A + ~B + 1, so c_out=1 means no borrow.
  assign sub_m = (op_sel == OP_SUB);
  assign b_x   = b[3:0] ^ {4{sub_m}};
  assign sum   = {1'b0, a[3:0]} + {1'b0, b_x} + {4'b0, sub_m};

  assign prod = {4'b0, a[3:0]} * {4'b0, b[3:0]};

  // A zero divisor is swapped for 1 so the divider never produces X; its output is discarded then.
  assign divisor  = b[2:0];
  assign div_zero = (divisor == 3'd0);
  assign safe_div = div_zero ? 3'd1 : divisor;
  assign quot     = a / {3'b0, safe_div};
  assign rem      = 3'(a % {3'b0, safe_div});

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data  = '0;
    carry = 1'b0;
    err   = 1'b0;
    unique case (op_sel)
      OP_ADD, OP_SUB: begin
        data  = {5'b0, sum[3:0]};
        carry = sum[4];
      end
      OP_MUL: data = {1'b0, prod};
      OP_DIV: begin
        if (div_zero) begin
          data = DIV0_CODE;
          err  = 1'b1;
        end else begin
          data = {rem, quot};
        end
      end
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Single-issue ALU front end: accepts a request, holds operands while the units settle, presents a registered result.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [5:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [8:0]       res_data,
  output logic             res_carry,
  output logic             res_err,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [WAIT_W-1:0] DIV_WAIT   = WAIT_W'(DIV_CYCLES);
  localparam logic [WAIT_W-1:0] SHORT_WAIT = WAIT_W'(1);

  state_e             state;
  state_e             next_state;
  logic               latch_req;
  logic               capture;
  logic               consume;
  logic [1:0]         op_q;
  logic [A_W-1:0]     a_q;
  logic [B_W-1:0]     b_q;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [RES_W-1:0]   unit_data;
  logic               unit_carry;
  logic               unit_err;

  // Operands stay frozen from accept to capture, which makes the divider a multicycle path.
  alu_exec_unit u_exec (
    .op    (op_q),
    .a     (a_q),
    .b     (b_q),
    .data  (unit_data),
    .carry (unit_carry),
    .err   (unit_err)
  );

  assign in_ready  = (state == IDLE);
  assign res_valid = (state == DONE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    latch_req  = 1'b0;
    capture    = 1'b0;
    consume    = 1'b0;
    unique case (state)
      IDLE: if (in_valid) begin
        latch_req  = 1'b1;
        next_state = EXEC;
      end
      EXEC: if (wait_cnt == '0) begin
        capture    = 1'b1;
        next_state = DONE;
      end
      DONE: if (res_ready) begin
        consume    = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      wait_cnt  <= '0;
      res_data  <= '0;
      res_carry <= 1'b0;
      res_err   <= 1'b0;
      op_count  <= '0;
    end else begin
      if (latch_req) begin
        op_q     <= in_op;
        a_q      <= in_a;
        b_q      <= in_b;
        wait_cnt <= (in_op == OP_DIV) ? DIV_WAIT : SHORT_WAIT;
      end else if (state == EXEC && wait_cnt != '0) begin
        wait_cnt <= wait_cnt - 1'b1;
      end
      if (capture) begin
        res_data  <= unit_data;
        res_carry <= unit_carry;
        res_err   <= unit_err;
      end
      if (consume) op_count <= op_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed scoreboard bench for alu_issue_stage: latency, packing, div-by-zero, backpressure, async reset, counter wrap.
module tb_alu_issue_stage;

  localparam int DIV_CYCLES = 2;
  localparam int CNT_W      = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [5:0]       in_a;
  logic [3:0]       in_b;
  logic             res_valid;
  logic             res_ready;
  logic [8:0]       res_data;
  logic             res_carry;
  logic             res_err;
  logic [CNT_W-1:0] op_count;

  int               checks   = 0;
  int               failures = 0;
  logic [CNT_W-1:0] exp_count = '0;
  logic [10:0]      sb[$];
  logic [8:0]       d;

  always #5 clk = ~clk;

  alu_issue_stage #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_carry (res_carry),
    .res_err   (res_err),
    .op_count  (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference result {err, carry, data} computed with integer arithmetic.
  function automatic logic [10:0] model(input logic [1:0] op, input logic [5:0] a, input logic [3:0] b);
    int x, y, dv;
    logic [8:0] data;
    logic c, e;
    x = int'(a[3:0]);
    y = int'(b[3:0]);
    dv = int'(b[2:0]);
    data = '0;
    c = 1'b0;
    e = 1'b0;
    case (op)
      2'b00: begin data = 9'((x + y) % 16); c = (x + y) >= 16; end
      2'b01: begin data = 9'((x - y + 16) % 16); c = (x >= y); end
      2'b10: data = 9'(x * y);
      default: begin
        if (dv == 0) begin
          data = 9'h1FF;
          e = 1'b1;
        end else begin
          data = 9'((int'(a) % dv) * 64 + int'(a) / dv);
        end
      end
    endcase
    return {e, c, data};
  endfunction

  // Called at a falling edge; returns at the falling edge where the result is first visible.
  task automatic send(input logic [1:0] op, input logic [5:0] a, input logic [3:0] b, output logic [8:0] obs);
    int k;
    int lat;
    logic [10:0] exp;
    lat = (op == 2'b11) ? 1 + DIV_CYCLES : 2;
    sb.push_back(model(op, a, b));
    in_op = op;
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    check("accept_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    k = 0;
    while (!res_valid && k < 20) begin
      @(posedge clk);
      @(negedge clk);
      k++;
    end
    check("latency", k, lat);
    exp = sb.pop_front();
    check("res_data", res_data, exp[8:0]);
    check("res_carry", res_carry, exp[9]);
    check("res_err", res_err, exp[10]);
    obs = res_data;
  endtask

  task automatic release_res();
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    exp_count++;
    check("op_count", op_count, exp_count);
    check("res_valid_clr", res_valid, 0);
    check("in_ready_back", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0;
    in_op = '0;
    in_a = '0;
    in_b = '0;
    res_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_res_carry", res_carry, 0);
    check("rst_res_err", res_err, 0);
    check("rst_op_count", op_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    send(2'b00, 6'd10, 4'd5, d);  check("add_10_5", d, 15);   release_res();
    send(2'b01, 6'd10, 4'd3, d);  check("sub_10_3", d, 7);    check("sub_no_borrow", res_carry, 1); release_res();
    send(2'b01, 6'd3, 4'd10, d);  check("sub_3_10", d, 9);    check("sub_borrow", res_carry, 0);    release_res();
    send(2'b10, 6'd15, 4'd15, d); check("mul_15_15", d, 225); release_res();
    send(2'b11, 6'd45, 4'd6, d);  check("div_45_6", d, 9'h0C7); release_res();
    send(2'b11, 6'd33, 4'b1000, d); check("div0_code", d, 9'h1FF); check("div0_err", res_err, 1); release_res();
    send(2'b00, 6'd1, 4'd1, d);   check("add_after_div0", d, 2); check("err_cleared", res_err, 0); release_res();

    // Backpressure: result must hold while res_ready is low, and a pulsed request is ignored.
    send(2'b10, 6'd3, 4'd4, d);   check("mul_3_4", d, 12);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        in_valid = 1'b1;
        in_op = 2'b00;
        in_a = 6'd1;
        in_b = 4'd1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
      check("bp_data", res_data, 12);
      check("bp_valid", res_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_res();
    @(posedge clk);
    @(negedge clk);
    check("no_ghost_valid", res_valid, 0);
    check("no_ghost_ready", in_ready, 1);

    // Asynchronous reset in the middle of a divide.
    in_op = 2'b11;
    in_a = 6'd45;
    in_b = 4'd6;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("exec_busy", in_ready, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_in_ready", in_ready, 1);
    check("arst_res_valid", res_valid, 0);
    check("arst_res_data", res_data, 0);
    check("arst_op_count", op_count, 0);
    exp_count = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("arst_no_result", res_valid, 0);
    end

    for (int i = 0; i < 256; i++) begin
      send(2'b00, 6'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), d);
      release_res();
    end
    check("op_count_wrap", op_count, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
